// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet line renderer.
// BULLET_OUTLINE_EN adds an edge_row flag so bullets draw as outlines.
package bullet_pkg;

    localparam int NUM_SLOTS_DEF = 8;
    localparam int COORD_W_DEF   = 8;
    localparam int COLOR_W_DEF   = 3;

    localparam int POS_X_HI  = 15;
    localparam int POS_X_LO  = 8;
    localparam int POS_Y_HI  = 7;
    localparam int POS_Y_LO  = 0;
    localparam int SIZE_W_HI = 15;
    localparam int SIZE_W_LO = 8;
    localparam int SIZE_H_HI = 7;
    localparam int SIZE_H_LO = 0;

    typedef struct packed {
        logic                   valid;
        logic [COORD_W_DEF-1:0] x_start;
        logic [COORD_W_DEF:0]   x_end;
        logic [COLOR_W_DEF-1:0] color;
`ifdef BULLET_OUTLINE_EN
        logic                   edge_row;
`endif
    } span_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY
    } state_t;

endpackage

// File: rtl/bullet_line_renderer_if.sv
// Dual combinational read port into the bullet attribute table.
// The renderer drives indices; the table answers in the same cycle.
interface bullet_line_renderer_if #(
    parameter int COLOR_W = 3
);
    logic [2:0]         index1;
    logic [2:0]         index2;
    logic [15:0]        position1;
    logic [15:0]        size1;
    logic [COLOR_W-1:0] color1;
    logic               isRender1;
    logic [15:0]        position2;
    logic [15:0]        size2;
    logic [COLOR_W-1:0] color2;
    logic               isRender2;

    modport master (
        output index1, index2,
        input  position1, size1, color1, isRender1,
        input  position2, size2, color2, isRender2
    );

    modport slave (
        input  index1, index2,
        output position1, size1, color1, isRender1,
        output position2, size2, color2, isRender2
    );
endinterface

// File: rtl/bullet_span_check.sv
// Tests one table slot against the current line and forms its span.
// Sums are one bit wider than coordinates so edges never wrap.
module bullet_span_check
    import bullet_pkg::*;
(
    input  logic [COORD_W_DEF-1:0] line_y,
    input  logic [15:0]            position,
    input  logic [15:0]            size,
    input  logic [COLOR_W_DEF-1:0] color,
    input  logic                   is_render,
    output span_t                  span
);
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] w;
    logic [COORD_W_DEF-1:0] h;
    logic [COORD_W_DEF:0]   y_end;

    assign x     = position[POS_X_HI:POS_X_LO];
    assign y     = position[POS_Y_HI:POS_Y_LO];
    assign w     = size[SIZE_W_HI:SIZE_W_LO];
    assign h     = size[SIZE_H_HI:SIZE_H_LO];
    assign y_end = {1'b0, y} + {1'b0, h};

    always_comb begin
        span         = '0;
        span.valid   = is_render && (y <= line_y)
                       && ({1'b0, line_y} < y_end);
        span.x_start = x;
        span.x_end   = {1'b0, x} + {1'b0, w};
        span.color   = color;
`ifdef BULLET_OUTLINE_EN
        span.edge_row = (line_y == y)
                        || ({1'b0, line_y} == y_end - 1'b1);
`endif
    end
endmodule

// File: rtl/bullet_line_renderer.sv
// Per-scanline bullet span builder and pixel hit/colour responder.
// BULLET_OUTLINE_EN: hits only on the 1-pixel border of each bullet.
module bullet_line_renderer
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int COLOR_W   = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_start,
    input  logic [COORD_W-1:0] line_y,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] pixel_x,
    bullet_line_renderer_if.master tbl,
    output logic               line_ready,
    output logic               pixel_hit,
    output logic [COLOR_W-1:0] pixel_color
);
    localparam int PAIRS = NUM_SLOTS / 2;
    localparam int KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    state_t             state;
    state_t             state_nx;
    logic [KW-1:0]      k;
    logic [KW-1:0]      k_nx;
    logic [COORD_W-1:0] ly;
    span_t              spans [NUM_SLOTS];
    span_t              s1;
    span_t              s2;
    logic               q_hit;
    logic [COLOR_W-1:0] q_color;

    bullet_span_check u_chk1 (
        .line_y    (ly),
        .position  (tbl.position1),
        .size      (tbl.size1),
        .color     (tbl.color1),
        .is_render (tbl.isRender1),
        .span      (s1)
    );

    bullet_span_check u_chk2 (
        .line_y    (ly),
        .position  (tbl.position2),
        .size      (tbl.size2),
        .color     (tbl.color2),
        .is_render (tbl.isRender2),
        .span      (s2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            ly    <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            if (line_start) ly <= line_y;
        end
    end

    // A new line pulse wins over everything, including a fetch in flight.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        if (line_start) begin
            state_nx = FETCH;
            k_nx     = '0;
        end else begin
            case (state)
                FETCH: begin
                    if (k == KW'(PAIRS - 1)) state_nx = READY;
                    else k_nx = k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign line_ready = (state == READY);
    assign tbl.index1 = (state == FETCH) ? 3'({k, 1'b0}) : 3'd0;
    assign tbl.index2 = (state == FETCH) ? 3'({k, 1'b1}) : 3'd0;

    always_ff @(posedge clk) begin
        if (!rst_n || line_start) begin
            for (int i = 0; i < NUM_SLOTS; i++) spans[i].valid <= 1'b0;
        end else if (state == FETCH) begin
            spans[{k, 1'b0}] <= s1;
            spans[{k, 1'b1}] <= s2;
        end
    end

    // Descending scan so the lowest matching slot is the final writer.
    always_comb begin
        q_hit   = 1'b0;
        q_color = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (spans[i].valid && (spans[i].x_start <= pixel_x)
                && ({1'b0, pixel_x} < spans[i].x_end)
`ifdef BULLET_OUTLINE_EN
                && (spans[i].edge_row || (pixel_x == spans[i].x_start)
                    || ({1'b0, pixel_x} == spans[i].x_end - 1'b1))
`endif
            ) begin
                q_hit   = 1'b1;
                q_color = spans[i].color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_hit   <= 1'b0;
            pixel_color <= '0;
        end else if (pixel_valid && (state == READY) && q_hit) begin
            pixel_hit   <= 1'b1;
            pixel_color <= q_color;
        end else begin
            pixel_hit   <= 1'b0;
            pixel_color <= '0;
        end
    end
endmodule

// File: tb/tb_bullet_line_renderer.sv
// Directed bench for bullet_line_renderer with a behavioural table.
module tb_bullet_line_renderer;
    import bullet_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_start;
    logic [7:0] line_y;
    logic       pixel_valid;
    logic [7:0] pixel_x;
    logic       line_ready;
    logic       pixel_hit;
    logic [2:0] pixel_color;

    logic [15:0] pos [8];
    logic [15:0] sz  [8];
    logic [2:0]  col [8];
    logic        ren [8];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bullet_line_renderer_if #(.COLOR_W(3)) tbl ();

    assign tbl.position1 = pos[tbl.index1];
    assign tbl.size1     = sz[tbl.index1];
    assign tbl.color1    = col[tbl.index1];
    assign tbl.isRender1 = ren[tbl.index1];
    assign tbl.position2 = pos[tbl.index2];
    assign tbl.size2     = sz[tbl.index2];
    assign tbl.color2    = col[tbl.index2];
    assign tbl.isRender2 = ren[tbl.index2];

    bullet_line_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_start  (line_start),
        .line_y      (line_y),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .tbl         (tbl),
        .line_ready  (line_ready),
        .pixel_hit   (pixel_hit),
        .pixel_color (pixel_color)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_line(input logic [7:0] y);
        line_start = 1'b1;
        line_y     = y;
        tick();
        line_start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic query(input string tag, input logic [7:0] x,
                         input logic eh, input logic [2:0] ec);
        pixel_valid = 1'b1;
        pixel_x     = x;
        tick();
        pixel_valid = 1'b0;
        chk({tag, ".hit"}, 32'(pixel_hit), 32'(eh));
        chk({tag, ".col"}, 32'(pixel_color), 32'(ec));
    endtask

    task automatic set_slot(input int i, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] w,
                            input logic [7:0] h, input logic [2:0] c);
        pos[i] = {x, y};
        sz[i]  = {w, h};
        col[i] = c;
        ren[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            pos[i] = '0;
            sz[i]  = '0;
            col[i] = '0;
            ren[i] = 1'b0;
        end
        rst_n       = 1'b0;
        line_start  = 1'b0;
        line_y      = '0;
        pixel_valid = 1'b0;
        pixel_x     = '0;
        repeat (2) tick();
        chk("rst.ready", 32'(line_ready), 32'd0);
        chk("rst.hit", 32'(pixel_hit), 32'd0);
        chk("rst.col", 32'(pixel_color), 32'd0);
        chk("rst.idx1", 32'(tbl.index1), 32'd0);
        chk("rst.idx2", 32'(tbl.index2), 32'd0);
        rst_n = 1'b1;
        tick();

        set_slot(1, 8'd85, 8'd100, 8'd15, 8'd20, 3'd1);
        line_start = 1'b1;
        line_y     = 8'd110;
        tick();
        line_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fetch%0d.idx1", k), 32'(tbl.index1), 32'(2 * k));
            chk($sformatf("fetch%0d.idx2", k), 32'(tbl.index2),
                32'(2 * k + 1));
            chk($sformatf("fetch%0d.rdy", k), 32'(line_ready), 32'd0);
            tick();
        end
        chk("fetch.done", 32'(line_ready), 32'd1);
        query("l110_x85", 8'd85, 1'b1, 3'd1);
        query("l110_x99", 8'd99, 1'b1, 3'd1);
        query("l110_x100", 8'd100, 1'b0, 3'd0);
        query("l110_x84", 8'd84, 1'b0, 3'd0);

        do_line(8'd99);
        query("l99_x90", 8'd90, 1'b0, 3'd0);
        do_line(8'd120);
        query("l120_x90", 8'd90, 1'b0, 3'd0);
        do_line(8'd119);
        query("l119_x90", 8'd90, 1'b1, 3'd1);

        ren[1] = 1'b0;
        set_slot(2, 8'd38, 8'd45, 8'd5, 8'd10, 3'd3);
        set_slot(5, 8'd35, 8'd50, 8'd10, 8'd1, 3'd6);
        do_line(8'd50);
        query("ovl_x40", 8'd40, 1'b1, 3'd3);
        query("ovl_x43", 8'd43, 1'b1, 3'd6);
        query("ovl_x45", 8'd45, 1'b0, 3'd0);
        ren[2] = 1'b0;
        ren[5] = 1'b0;

        set_slot(0, 8'd250, 8'd250, 8'd10, 8'd10, 3'd5);
        do_line(8'd255);
        query("wrap_x255", 8'd255, 1'b1, 3'd5);
        query("wrap_x249", 8'd249, 1'b0, 3'd0);
        pixel_x = 8'd255;
        tick();
        chk("novalid.hit", 32'(pixel_hit), 32'd0);
        do_line(8'd4);
        query("wrap_l4_x2", 8'd2, 1'b0, 3'd0);

        ren[0] = 1'b0;
        do_line(8'd255);
        query("norender", 8'd255, 1'b0, 3'd0);
        ren[0] = 1'b1;

        line_start = 1'b1;
        line_y     = 8'd255;
        tick();
        line_start = 1'b0;
        query("fetchq", 8'd255, 1'b0, 3'd0);
        tick();
        chk("mid.idx1", 32'(tbl.index1), 32'd4);
        chk("mid.idx2", 32'(tbl.index2), 32'd5);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("rs.idx1", 32'(tbl.index1), 32'd0);
        chk("rs.idx2", 32'(tbl.index2), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("rs%0d.rdy", k), 32'(line_ready), 32'd0);
        end
        tick();
        chk("rs.ready", 32'(line_ready), 32'd1);

        line_start  = 1'b1;
        pixel_valid = 1'b1;
        pixel_x     = 8'd255;
        tick();
        line_start  = 1'b0;
        pixel_valid = 1'b0;
        chk("simul.hit", 32'(pixel_hit), 32'd1);
        chk("simul.col", 32'(pixel_color), 32'd5);
        repeat (4) tick();
        query("rs_x255", 8'd255, 1'b1, 3'd5);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2.ready", 32'(line_ready), 32'd0);
        query("rst2_x255", 8'd255, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
